load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- MEM-stage load/store unit that sits directly upstream of the word-wide data memory.
- The data memory has no byte enables, a 1-cycle registered-address read, and a word-indexed array.
- This block converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests from the EX/MEM register into word accesses. Sub-word stores use a 2-cycle read-modify-write (RMW) with a pipeline stall.
- It formats load data for WB and flags misaligned or illegal accesses.

Parameters:
- ADDR_W, 32, byte-address width from EX/MEM.
- DMEM_AW, 11, data memory word-index width (2048 words).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  EX/MEM slot holds a live instruction.
- i_mem_rd  input  1  load request.
- i_mem_wr  input  1  store request.
- i_funct3  input  3  RV32I width/sign code.
- i_addr  input  32  byte address.
- i_st_data  input  32  store source (rs2).
- i_dmem_load_data  input  32  word returned by data memory (addr registered last cycle).
- o_dmem_wren  output  1  data memory write enable.
- o_dmem_addr  output  32  word index = {2'b00, addr[31:2]}.
- o_dmem_st_data  output  32  full word to write.
- o_stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle.
- o_ld_valid  output  1  o_ld_data valid (cycle after load accept).
- o_ld_data  output  32  extended load result for WB.
- o_fault  output  1  1-cycle pulse: misaligned or illegal access.

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE. o_dmem_wren=0, o_stall=0, o_ld_valid=0, o_ld_data=0, o_fault=0. All capture registers=0.
- Accept condition: in IDLE, a request is accepted when i_valid & (i_mem_rd | i_mem_wr).
- Both rd and wr set: treated as store, o_fault pulses, no memory write.
- Alignment rules:
  - funct3 000/100 (byte): always aligned.
  - 001/101 (half): requires addr[0]=0.
  - 010 (word): requires addr[1:0]=0.
  - Loads with funct3 011/110/111 are illegal; stores with funct3 other than 000/001/010 are illegal.
  - Fault handling: no write, o_fault=1 the same cycle. A faulting load still sets o_ld_valid next cycle with o_ld_data=0.
- o_dmem_addr in IDLE: driven combinationally from i_addr. In RMW: driven from captured address.
- Load, no stall:
  - Cycle N: address presented; funct3 and addr[1:0] registered.
  - Cycle N+1: o_ld_valid=1. o_ld_data is selected combinationally from i_dmem_load_data by the registered offset: byte lane = off*8, half lane = off[1]*16.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- SW, no stall: cycle N sets o_dmem_wren=1 and o_dmem_st_data=i_st_data.
- SB/SH, two cycles:
  - IDLE, cycle N: o_dmem_wren=0, o_stall=1. Capture addr, funct3 and st_data. Go to RMW.
  - RMW, cycle N+1: i_dmem_load_data holds the old word. o_dmem_st_data = old word with the addressed byte/half lane replaced by st_data[7:0]/[15:0]. o_dmem_wren=1, o_stall=0. Return to IDLE.
  - Total: 1 stall cycle per sub-word store.
- Requests during RMW: EX/MEM is frozen during cycle N, so the RMW cycle sees the same instruction on the inputs. It is ignored; only captured values are used.
- Load immediately after store to the same word: the write commits at the same edge the memory registers the address, so the load returns the new data. No forwarding logic is required.
- Reset mid-RMW: return to IDLE, no write occurs, the partial store is lost, o_stall drops immediately.
- i_valid=0 (bubble): no write, no stall, o_ld_valid=0 next cycle.

Test Plan:
- Word-0 = 0x11223344. SB addr=0x1, data=0xAA → o_stall high for 1 cycle, then a write of 0x1122AA44. LW addr=0x0 returns 0x1122AA44.
- Word-1 = 0x8000F0FF:
  - LB addr=0x4 → 0xFFFFFFFF; LBU addr=0x4 → 0x000000FF.
  - LH addr=0x6 → 0xFFFF8000; LHU addr=0x6 → 0x00008000.
  - o_ld_valid one cycle after each request.
- SW addr=0x8, data=0xDEADBEEF → o_dmem_wren=1 the same cycle, o_dmem_addr=0x2, no stall. Back-to-back LW addr=0x8 → 0xDEADBEEF.
- LW addr=0x6, SH addr=0x3, and load funct3=3 → o_fault pulse each time, o_dmem_wren stays 0, faulting loads return 0.
- SH addr=0x2 issued, i_rst_n pulled low during the RMW cycle → o_dmem_wren=0, o_stall=0, and memory word 0 is unchanged.

Source files
------------

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit in front of a word-wide data memory without byte enables.
// Sub-word stores become a one-stall read-modify-write; loads are lane-selected and extended.
module load_store_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DMEM_AW = 11
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic              i_mem_rd,
  input  logic              i_mem_wr,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_st_data,
  input  logic [31:0]       i_dmem_load_data,
  output logic              o_dmem_wren,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [31:0]       o_dmem_st_data,
  output logic              o_stall,
  output logic              o_ld_valid,
  output logic [31:0]       o_ld_data,
  output logic              o_fault
);

  typedef enum logic [0:0] {StIdle, StRmw} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-3:0] rmw_idx_q, rmw_idx_d;
  logic [1:0]        rmw_off_q, rmw_off_d;
  logic              rmw_half_q, rmw_half_d;
  logic [15:0]       rmw_data_q, rmw_data_d;
  logic              ld_pend_q, ld_pend_d;
  logic              ld_fault_q, ld_fault_d;
  logic [1:0]        ld_off_q, ld_off_d;
  logic [2:0]        ld_f3_q, ld_f3_d;

  logic              accept;
  logic              misaligned;
  logic              illegal;
  logic              fault;
  logic [ADDR_W-3:0] word_idx;
  logic [31:0]       merged;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;

  // The memory only decodes the low DMEM_AW index bits; the rest pass through unchanged.
  assign word_idx = {i_addr[ADDR_W-1:DMEM_AW+2], i_addr[DMEM_AW+1:2]};

  // Request decode; reset gates acceptance so nothing stalls or writes while held in reset.
  always_comb begin
    accept     = i_rst_n & i_valid & (i_mem_rd | i_mem_wr) & (state_q == StIdle);
    misaligned = ((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                 ((i_funct3[1:0] == 2'b10) & (|i_addr[1:0]));
    if (i_mem_wr) begin
      illegal = (i_funct3 > 3'b010);
    end else begin
      illegal = (i_funct3 == 3'b011) | (i_funct3 == 3'b110) | (i_funct3 == 3'b111);
    end
    fault = (i_mem_rd & i_mem_wr) | illegal | misaligned;
  end

  // Old word from memory with the captured lane replaced.
  always_comb begin
    merged = i_dmem_load_data;
    if (rmw_half_q) begin
      if (rmw_off_q[1]) merged[31:16] = rmw_data_q;
      else              merged[15:0]  = rmw_data_q;
    end else begin
      merged[{rmw_off_q, 3'b000} +: 8] = rmw_data_q[7:0];
    end
  end

  always_comb begin
    state_d        = state_q;
    rmw_idx_d      = rmw_idx_q;
    rmw_off_d      = rmw_off_q;
    rmw_half_d     = rmw_half_q;
    rmw_data_d     = rmw_data_q;
    ld_pend_d      = 1'b0;
    ld_fault_d     = 1'b0;
    ld_off_d       = ld_off_q;
    ld_f3_d        = ld_f3_q;
    o_dmem_wren    = 1'b0;
    o_stall        = 1'b0;
    o_fault        = 1'b0;
    o_dmem_addr    = {2'b00, word_idx};
    o_dmem_st_data = i_st_data;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          o_fault = fault;
          if (!i_mem_wr) begin
            ld_pend_d  = 1'b1;
            ld_fault_d = fault;
            ld_off_d   = i_addr[1:0];
            ld_f3_d    = i_funct3;
          end else if (!fault) begin
            if (i_funct3[1]) begin
              o_dmem_wren = 1'b1;
            end else begin
              o_stall    = 1'b1;
              rmw_idx_d  = word_idx;
              rmw_off_d  = i_addr[1:0];
              rmw_half_d = i_funct3[0];
              rmw_data_d = i_st_data[15:0];
              state_d    = StRmw;
            end
          end
        end
      end
      StRmw: begin
        // Inputs still show the frozen store; only captured values matter here.
        o_dmem_addr    = {2'b00, rmw_idx_q};
        o_dmem_st_data = merged;
        o_dmem_wren    = 1'b1;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Load result formatting from the offset registered with the request.
  always_comb begin
    lane_b = i_dmem_load_data[{ld_off_q, 3'b000} +: 8];
    lane_h = ld_off_q[1] ? i_dmem_load_data[31:16] : i_dmem_load_data[15:0];
    o_ld_valid = ld_pend_q;
    o_ld_data  = 32'h0;
    if (ld_pend_q && !ld_fault_q) begin
      case (ld_f3_q)
        3'b000:  o_ld_data = {{24{lane_b[7]}}, lane_b};
        3'b100:  o_ld_data = {24'h0, lane_b};
        3'b001:  o_ld_data = {{16{lane_h[15]}}, lane_h};
        3'b101:  o_ld_data = {16'h0, lane_h};
        3'b010:  o_ld_data = i_dmem_load_data;
        default: o_ld_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      rmw_idx_q  <= '0;
      rmw_off_q  <= '0;
      rmw_half_q <= 1'b0;
      rmw_data_q <= '0;
      ld_pend_q  <= 1'b0;
      ld_fault_q <= 1'b0;
      ld_off_q   <= '0;
      ld_f3_q    <= '0;
    end else begin
      state_q    <= state_d;
      rmw_idx_q  <= rmw_idx_d;
      rmw_off_q  <= rmw_off_d;
      rmw_half_q <= rmw_half_d;
      rmw_data_q <= rmw_data_d;
      ld_pend_q  <= ld_pend_d;
      ld_fault_q <= ld_fault_d;
      ld_off_q   <= ld_off_d;
      ld_f3_q    <= ld_f3_d;
    end
  end

endmodule
